// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: default widths, BRAM word types and the round-robin pointer
// helper shared by the BRAM arbiter files.
package bram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    // Pointer after a grant to idx: one past the winner, wrapping at num.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
        return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_if.sv
// bram_rr_arbiter_if: requester handshake, read response and BRAM port bundle.
// The master modport is the requester/BRAM side; the slave modport is the arbiter.
interface bram_rr_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    logic [ADDR_W-1:0]         bram_i_addr;
    logic [DATA_W-1:0]         bram_i_data;
    logic                      bram_write;
    logic [ADDR_W-1:0]         bram_o_addr;
    logic                      bram_read;
    logic [DATA_W-1:0]         bram_o_read;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bram_o_read,
        input  req_ready, rsp_valid, rsp_data,
               bram_i_addr, bram_i_data, bram_write, bram_o_addr, bram_read
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bram_o_read,
        output req_ready, rsp_valid, rsp_data,
               bram_i_addr, bram_i_data, bram_write, bram_o_addr, bram_read
    );

endinterface

// File: rtl/bram_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Priority starts at index ptr and
// wraps; returns a one-hot grant, its index and an any-grant flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  cand,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Two passes: indices at/above ptr first, then the wrapped indices below ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && cand[i] && (PW'(i) >= ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && cand[i] && (PW'(i) < ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter: shares one simple-dual-port BRAM between NUM_REQ requesters
// with independent round-robin arbitration on the write and read sides.
// Read data returns one cycle after the grant with a one-hot response tag.
// Optional macro BRAM_ARB_FWD_EN: forward same-cycle write data to a read of
// the same address (new data) instead of returning the BRAM's old data.
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    bram_rr_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NUM_REQ-1:0] wr_cand, rd_cand;
    logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
    logic [PTR_W-1:0]   wr_idx, rd_idx;
    logic               wr_any, rd_any;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_hold_q, rsp_hold_d;
    logic [DATA_W-1:0]  rd_src;

    // Split requests by direction; reset masks everything so no grant leaks out.
    always_comb begin
        wr_cand = '0;
        rd_cand = '0;
        if (!rst) begin
            wr_cand = bus.req_valid & bus.req_we;
            rd_cand = bus.req_valid & ~bus.req_we;
        end
    end

    rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_wr_pick (
        .cand    (wr_cand),
        .ptr     (wr_ptr_q),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx),
        .gnt_any (wr_any)
    );

    rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_rd_pick (
        .cand    (rd_cand),
        .ptr     (rd_ptr_q),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx),
        .gnt_any (rd_any)
    );

    // One-hot AND-OR winner mux; an idle side drives zero address/data.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wr_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                wr_data = bus.req_wdata[i*DATA_W +: DATA_W];
            end
            if (rd_gnt[i]) begin
                rd_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign bus.req_ready   = wr_gnt | rd_gnt;
    assign bus.bram_write  = wr_any;
    assign bus.bram_i_addr = wr_addr;
    assign bus.bram_i_data = wr_data;
    assign bus.bram_read   = rd_any;
    assign bus.bram_o_addr = rd_addr;

    // Advance each pointer past its winner; hold when that side is idle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_any) begin
            wr_ptr_d = PTR_W'(rr_next(32'(wr_idx), NUM_REQ));
        end
        if (rd_any) begin
            rd_ptr_d = PTR_W'(rr_next(32'(rd_idx), NUM_REQ));
        end
    end

`ifdef BRAM_ARB_FWD_EN
    logic              fwd_we_q, fwd_we_d;
    logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    // Capture this cycle's write and read address for the next-cycle hit compare.
    always_comb begin
        fwd_we_d   = wr_any;
        fwd_addr_d = wr_addr;
        fwd_data_d = wr_data;
        rd_addr_d  = rd_addr;
    end

    // Forwarding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_we_q   <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            fwd_we_q   <= fwd_we_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // The BRAM returns old data on a collision; substitute the new write data.
    assign rd_src = (fwd_we_q && (fwd_addr_q == rd_addr_q)) ? fwd_data_q : bus.bram_o_read;
`else
    assign rd_src = bus.bram_o_read;
`endif

    // Response tag follows the read grant by one cycle; data is held between responses.
    always_comb begin
        rsp_valid_d = rd_gnt;
        rsp_hold_d  = rsp_hold_q;
        if (|rsp_valid_q) begin
            rsp_hold_d = rd_src;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = (|rsp_valid_q) ? rd_src : rsp_hold_q;

    // Pointer and response registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_hold_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hold_q  <= rsp_hold_d;
        end
    end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb_bram_rr_arbiter: directed bench for bram_rr_arbiter with a behavioural
// 256x8 BRAM (registered read, read-before-write on collisions).
module tb_bram_rr_arbiter;
    import bram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bram_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BRAM model: contents are never reset.
    data_t mem [256];
    always @(posedge clk) begin
        if (bus.bram_write) mem[bus.bram_i_addr] <= bus.bram_i_data;
        if (bus.bram_read)  bus.bram_o_read     <= mem[bus.bram_o_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input addr_t a, input data_t d);
        bus.req_valid[i]          = 1'b1;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    data_t hazard_exp;
    data_t exp_rd [N];
    logic [3:0] onehot;
    logic [3:0] prev;

    initial begin
`ifdef BRAM_ARB_FWD_EN
        hazard_exp = 8'h99;
`else
        hazard_exp = 8'h11;
`endif
        exp_rd[0] = 8'hA5;
        exp_rd[1] = 8'h77;
        exp_rd[2] = 8'h11;
        exp_rd[3] = 8'hA5;

        // Reset with active requests: nothing may be granted.
        rst = 1'b1;
        clr();
        set_req(0, 1'b1, 8'h01, 8'h01);
        set_req(1, 1'b0, 8'h02, 8'h00);
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready",     32'(bus.req_ready),  32'h0);
        chk("rst_bram_wr",   32'(bus.bram_write), 32'h0);
        chk("rst_bram_rd",   32'(bus.bram_read),  32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid),  32'h0);
        chk("rst_rsp_data",  32'(bus.rsp_data),   32'h0);
        tick();
        rst = 1'b0;

        // Single write then read.
        clr();
        set_req(0, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        chk("w1_ready",  32'(bus.req_ready),   32'h1);
        chk("w1_we",     32'(bus.bram_write),  32'h1);
        chk("w1_addr",   32'(bus.bram_i_addr), 32'h10);
        chk("w1_data",   32'(bus.bram_i_data), 32'hA5);
        chk("w1_rd",     32'(bus.bram_read),   32'h0);
        tick();
        clr();
        set_req(0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk("r1_ready",  32'(bus.req_ready),   32'h1);
        chk("r1_rd",     32'(bus.bram_read),   32'h1);
        chk("r1_oaddr",  32'(bus.bram_o_addr), 32'h10);
        chk("r1_we",     32'(bus.bram_write),  32'h0);
        chk("r1_iaddr",  32'(bus.bram_i_addr), 32'h0);
        tick();
        clr();
        @(negedge clk);
        chk("r1_rsp_v",  32'(bus.rsp_valid),   32'h1);
        chk("r1_rsp_d",  32'(bus.rsp_data),    32'hA5);
        chk("idle_rdy",  32'(bus.req_ready),   32'h0);
        tick();
        @(negedge clk);
        chk("hold_v",    32'(bus.rsp_valid),   32'h0);
        chk("hold_d",    32'(bus.rsp_data),    32'hA5);
        tick();

        // Preload 0x05 = 0x77 (wr_ptr 1 -> req1) and 0x30 = 0x11 (wr_ptr 2 -> req2).
        clr();
        set_req(1, 1'b1, 8'h05, 8'h77);
        @(negedge clk);
        chk("pre1_ready", 32'(bus.req_ready), 32'h2);
        tick();
        clr();
        set_req(2, 1'b1, 8'h30, 8'h11);
        @(negedge clk);
        chk("pre2_ready", 32'(bus.req_ready), 32'h4);
        tick();

        // Reset pulse, then all four read for 8 cycles.
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b0, 8'h05, 8'h00);
        set_req(2, 1'b0, 8'h30, 8'h00);
        set_req(3, 1'b0, 8'h10, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            onehot = 4'b0001 << (k % 4);
            chk("rot_ready", 32'(bus.req_ready), 32'(onehot));
            if (k > 0) begin
                prev = 4'b0001 << ((k - 1) % 4);
                chk("rot_rsp_v", 32'(bus.rsp_valid), 32'(prev));
                chk("rot_rsp_d", 32'(bus.rsp_data),  32'(exp_rd[(k - 1) % 4]));
            end else begin
                chk("rot_rsp_v0", 32'(bus.rsp_valid), 32'h0);
            end
            tick();
        end
        clr();
        @(negedge clk);
        chk("rot_last_v", 32'(bus.rsp_valid), 32'h8);
        chk("rot_last_d", 32'(bus.rsp_data),  32'hA5);
        chk("rot_idle",   32'(bus.req_ready), 32'h0);
        tick();

        // Concurrent write (req1) and read (req2) in one cycle.
        clr();
        set_req(1, 1'b1, 8'h20, 8'h3C);
        set_req(2, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        chk("cc_ready", 32'(bus.req_ready),   32'h6);
        chk("cc_iaddr", 32'(bus.bram_i_addr), 32'h20);
        chk("cc_idata", 32'(bus.bram_i_data), 32'h3C);
        chk("cc_oaddr", 32'(bus.bram_o_addr), 32'h05);
        tick();
        clr();
        @(negedge clk);
        chk("cc_rsp_v", 32'(bus.rsp_valid), 32'h4);
        chk("cc_rsp_d", 32'(bus.rsp_data),  32'h77);
        tick();

        // Same-address hazard: req0 writes 0x30 = 0x99, req3 reads 0x30.
        clr();
        set_req(0, 1'b1, 8'h30, 8'h99);
        set_req(3, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        chk("hz_ready", 32'(bus.req_ready), 32'h9);
        tick();
        clr();
        @(negedge clk);
        chk("hz_rsp_v", 32'(bus.rsp_valid), 32'h8);
        chk("hz_rsp_d", 32'(bus.rsp_data),  32'(hazard_exp));
        tick();
        clr();
        set_req(0, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        chk("hz2_ready", 32'(bus.req_ready), 32'h1);
        tick();
        clr();
        @(negedge clk);
        chk("hz2_rsp_v", 32'(bus.rsp_valid), 32'h1);
        chk("hz2_rsp_d", 32'(bus.rsp_data),  32'h99);
        tick();

        // Reset mid-read: rd_ptr is 1, req1 granted, then reset before the edge.
        clr();
        set_req(1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        chk("mr_ready", 32'(bus.req_ready), 32'h2);
        #1;
        rst = 1'b1;
        clr();
        tick();
        @(negedge clk);
        chk("mr_rsp_v", 32'(bus.rsp_valid), 32'h0);
        chk("mr_rsp_d", 32'(bus.rsp_data),  32'h0);
        chk("mr_rdy",   32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 8'h40, 8'h5A);
        set_req(3, 1'b1, 8'h50, 8'h66);
        set_req(1, 1'b0, 8'h20, 8'h00);
        set_req(2, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        chk("pr_ready", 32'(bus.req_ready),   32'h3);
        chk("pr_rsp_v", 32'(bus.rsp_valid),   32'h0);
        chk("pr_iaddr", 32'(bus.bram_i_addr), 32'h40);
        chk("pr_oaddr", 32'(bus.bram_o_addr), 32'h20);
        tick();
        clr();
        @(negedge clk);
        chk("pr_rsp_v2", 32'(bus.rsp_valid), 32'h2);
        chk("pr_rsp_d2", 32'(bus.rsp_data),  32'h3C);
        tick();

        // Read pointer wrap: rd_ptr is 2, req3 alone, then req0 and req3.
        clr();
        set_req(3, 1'b0, 8'h40, 8'h00);
        @(negedge clk);
        chk("wr3_ready", 32'(bus.req_ready), 32'h8);
        tick();
        set_req(0, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        chk("wrap_ready", 32'(bus.req_ready), 32'h1);
        chk("wrap_rsp_v", 32'(bus.rsp_valid), 32'h8);
        chk("wrap_rsp_d", 32'(bus.rsp_data),  32'h5A);
        tick();
        @(negedge clk);
        chk("wrap2_ready", 32'(bus.req_ready), 32'h8);
        chk("wrap2_rsp_v", 32'(bus.rsp_valid), 32'h1);
        chk("wrap2_rsp_d", 32'(bus.rsp_data),  32'h77);
        tick();
        clr();
        @(negedge clk);
        chk("wrap3_rsp_v", 32'(bus.rsp_valid), 32'h8);
        chk("wrap3_rsp_d", 32'(bus.rsp_data),  32'h5A);
        tick();

        // Write pointer wrap: wr_ptr is 1, req3 alone, then req0 and req3.
        clr();
        set_req(3, 1'b1, 8'h60, 8'hC3);
        @(negedge clk);
        chk("ww3_ready", 32'(bus.req_ready), 32'h8);
        tick();
        set_req(0, 1'b1, 8'h61, 8'hD4);
        @(negedge clk);
        chk("wwrap_ready", 32'(bus.req_ready),   32'h1);
        chk("wwrap_iaddr", 32'(bus.bram_i_addr), 32'h61);
        chk("wwrap_idata", 32'(bus.bram_i_data), 32'hD4);
        tick();
        clr();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Shares one 256x8 simple-dual-port BRAM (one write port, one registered read port) between NUM_REQ requesters.
- Independent round-robin arbitration on the write side and the read side, so up to one write and one read are granted per cycle.
- Returns read data with a one-hot response tag aligned to the BRAM's 1-cycle read latency.
- Sits between tree/queue logic and the node BRAM.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, BRAM address width
DATA_W, 8, BRAM data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  grant; a transfer occurs when valid & ready
rsp_valid  out  NUM_REQ  one-hot read response strobe
rsp_data  out  DATA_W  read response data
bram_i_addr  out  ADDR_W  BRAM write address
bram_i_data  out  DATA_W  BRAM write data
bram_write  out  1  BRAM write enable
bram_o_addr  out  ADDR_W  BRAM read address
bram_read  out  1  BRAM read enable
bram_o_read  in  DATA_W  BRAM registered read data

Behaviour:
- Write candidates: req_valid & req_we. Read candidates: req_valid & ~req_we. The two sides are arbitrated independently.
- Each side has its own pointer (wr_ptr, rd_ptr), width clog2(NUM_REQ).
  - Highest priority goes to index == ptr, then ptr+1, and so on, wrapping modulo NUM_REQ.
  - On a grant to index g, ptr <= (g+1) mod NUM_REQ.
  - With no grant, ptr holds.
- req_ready is combinational from req_valid and the pointers; at most one write grant and one read grant per cycle.
  - A requester's valid must not depend on its ready.
  - While valid and not ready, addr/wdata/we must stay stable.
- BRAM drive:
  - bram_write = any write grant; bram_i_addr/bram_i_data come from the write winner.
  - bram_read = any read grant; bram_o_addr comes from the read winner.
  - Address/data outputs are don't-care when the matching enable is 0 and are driven 0.
- Read latency:
  - A read granted in cycle T yields rsp_valid[g] = 1 in cycle T+1 (registered tag), with rsp_data = bram_o_read.
  - rsp_data holds its last value when no response is active.
- Same-address read and write in one cycle: the BRAM returns the OLD data (without the optional feature below).
- Reset:
  - While rst = 1: req_ready = 0, bram_write = 0, bram_read = 0.
  - Reset values: rsp_valid = 0, rsp_data = 0, wr_ptr = 0, rd_ptr = 0.
  - Reset mid-operation drops any in-flight read response (no rsp_valid after release).
  - BRAM contents are not cleared.
- Wrap-around: after a grant to NUM_REQ-1 the pointer returns to 0.
- All requesters valid continuously: grants rotate 0,1,...,NUM_REQ-1,0 with no starvation; worst-case wait is NUM_REQ-1 cycles.

Optional Feature:
- Macro BRAM_ARB_FWD_EN.
- Defined: the response path registers the write address, data and enable of cycle T.
  - If a read in cycle T hits the same address as the write in cycle T, rsp_data in T+1 = write data of T (new data).
  - Adds a DATA_W+ADDR_W+1 bit register stage and a compare.
- Undefined: no forwarding; old data is returned.

Decomposition:
- Package bram_arb_pkg:
  - ADDR_W_DEF = 8, DATA_W_DEF = 8.
  - Typedefs addr_t and data_t.
  - Function for the next round-robin pointer.
- Sub-module rr_pick:
  - Inputs: candidate mask and pointer. Outputs: one-hot grant and grant index.
  - Purely combinational; instantiated twice (write side and read side).
- Pointer and response registers live in bram_rr_arbiter.

Test Plan:
- Single write then read: req0 writes addr 0x10 data 0xA5; next cycle req0 reads 0x10 → rsp_valid = 0001 one cycle later, rsp_data = 0xA5.
- Read contention: all 4 requesters read held for 8 cycles after reset → grants 0,1,2,3,0,1,2,3; rsp_valid follows with 1-cycle lag.
- Concurrent sides: req1 writes 0x20 = 0x3C while req2 reads 0x05 (preloaded 0x77), same cycle → both ready = 1; next cycle rsp_valid = 0100, rsp_data = 0x77.
- Same-address hazard: addr 0x30 holds 0x11; req0 writes 0x30 = 0x99 and req3 reads 0x30 in the same cycle → rsp_data = 0x11 without BRAM_ARB_FWD_EN, 0x99 with it.
- Reset mid-read: read granted in cycle T, rst asserted asynchronously before edge T+1 → rsp_valid stays 0, pointers = 0, first post-reset grant goes to requester 0.
- Pointer wrap: only req3 requests (grant), then req0 and req3 request together → req0 granted first (ptr wrapped to 0).
